// File: rtl/ex_stage_if.sv
// Signal bundle between the ID/EX stage, the execute stage and the MEM stage.
// The execute stage uses the slave modport; whoever drives ID/EX uses master.
interface ex_stage_if #(
  parameter int unsigned XLEN = 32
);
  // Pipeline control
  logic            stall;
  logic            flush;
  // ID/EX register contents
  logic            id_ex_valid;
  logic [XLEN-1:0] id_ex_pc;
  logic [XLEN-1:0] id_ex_pc_plus_4;
  logic [XLEN-1:0] id_ex_reg_a;
  logic [XLEN-1:0] id_ex_reg_b;
  logic [XLEN-1:0] id_ex_imm;
  logic [4:0]      id_ex_rd;
  logic            id_ex_regwrite_d;
  logic            id_ex_memwrite_d;
  logic            id_ex_jump_d;
  logic            id_ex_branch_d;
  logic            id_ex_alu_src_d;
  logic            id_ex_jalr_d;
  logic [2:0]      id_ex_branch_funct3;
  logic [1:0]      id_ex_result_src_d;
  logic [3:0]      id_ex_alu_control_d;
  // Forwarding
  logic [1:0]      fwd_a_sel;
  logic [1:0]      fwd_b_sel;
  logic [XLEN-1:0] wb_data;
  // Redirect back to IF
  logic            pc_src;
  logic [XLEN-1:0] pc_branch_dest;
  // EX/MEM register outputs
  logic            ex_mem_valid;
  logic            ex_mem_regwrite;
  logic            ex_mem_memwrite;
  logic [1:0]      ex_mem_result_src;
  logic [4:0]      ex_mem_rd;
  logic [XLEN-1:0] ex_mem_alu_result;
  logic [XLEN-1:0] ex_mem_reg_b;
  logic [XLEN-1:0] ex_mem_pc_plus_4;

  modport master (
    output stall, flush, id_ex_valid, id_ex_pc, id_ex_pc_plus_4, id_ex_reg_a, id_ex_reg_b,
           id_ex_imm, id_ex_rd, id_ex_regwrite_d, id_ex_memwrite_d, id_ex_jump_d,
           id_ex_branch_d, id_ex_alu_src_d, id_ex_jalr_d, id_ex_branch_funct3,
           id_ex_result_src_d, id_ex_alu_control_d, fwd_a_sel, fwd_b_sel, wb_data,
    input  pc_src, pc_branch_dest, ex_mem_valid, ex_mem_regwrite, ex_mem_memwrite,
           ex_mem_result_src, ex_mem_rd, ex_mem_alu_result, ex_mem_reg_b, ex_mem_pc_plus_4
  );

  modport slave (
    input  stall, flush, id_ex_valid, id_ex_pc, id_ex_pc_plus_4, id_ex_reg_a, id_ex_reg_b,
           id_ex_imm, id_ex_rd, id_ex_regwrite_d, id_ex_memwrite_d, id_ex_jump_d,
           id_ex_branch_d, id_ex_alu_src_d, id_ex_jalr_d, id_ex_branch_funct3,
           id_ex_result_src_d, id_ex_alu_control_d, fwd_a_sel, fwd_b_sel, wb_data,
    output pc_src, pc_branch_dest, ex_mem_valid, ex_mem_regwrite, ex_mem_memwrite,
           ex_mem_result_src, ex_mem_rd, ex_mem_alu_result, ex_mem_reg_b, ex_mem_pc_plus_4
  );
endinterface

// File: rtl/ex_stage.sv
// RV32I execute stage: operand forwarding, ALU, branch/jump resolution and the
// EX/MEM pipeline register (synchronous active-low reset > flush > stall > load).
module ex_stage #(
  parameter int unsigned XLEN         = 32,
  parameter logic        RESET_ACTIVE = 1'b0
) (
  input logic       clk,
  input logic       reset,
  ex_stage_if.slave bus
);
  logic [XLEN-1:0] op_a, fwd_b, op_b, alu_res, jalr_sum;
  logic            taken;

  logic            valid_q, valid_d;
  logic            regwrite_q, regwrite_d;
  logic            memwrite_q, memwrite_d;
  logic [1:0]      result_src_q, result_src_d;
  logic [4:0]      rd_q, rd_d;
  logic [XLEN-1:0] alu_result_q, alu_result_d;
  logic [XLEN-1:0] reg_b_q, reg_b_d;
  logic [XLEN-1:0] pc_plus_4_q, pc_plus_4_d;

  // Forwarding muxes; 01 takes this stage's own registered ALU result
  always_comb begin
    op_a  = bus.id_ex_reg_a;
    fwd_b = bus.id_ex_reg_b;
    case (bus.fwd_a_sel)
      2'b01:   op_a = alu_result_q;
      2'b10:   op_a = bus.wb_data;
      default: op_a = bus.id_ex_reg_a;
    endcase
    case (bus.fwd_b_sel)
      2'b01:   fwd_b = alu_result_q;
      2'b10:   fwd_b = bus.wb_data;
      default: fwd_b = bus.id_ex_reg_b;
    endcase
    op_b = bus.id_ex_alu_src_d ? bus.id_ex_imm : fwd_b;
  end

  // ALU
  always_comb begin
    alu_res = '0;
    case (bus.id_ex_alu_control_d)
      4'b0000: alu_res = op_a + op_b;
      4'b0001: alu_res = op_a - op_b;
      4'b0010: alu_res = op_a & op_b;
      4'b0011: alu_res = op_a | op_b;
      4'b0100: alu_res = op_a ^ op_b;
      4'b0101: alu_res = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
      4'b0110: alu_res = {{(XLEN-1){1'b0}}, op_a < op_b};
      4'b0111: alu_res = op_a << op_b[4:0];
      4'b1000: alu_res = op_a >> op_b[4:0];
      4'b1001: alu_res = $unsigned($signed(op_a) >>> op_b[4:0]);
      4'b1010: alu_res = op_b;
      default: alu_res = '0;
    endcase
  end

  // Branch condition compares the forwarded register operands, never the immediate
  always_comb begin
    taken = 1'b0;
    case (bus.id_ex_branch_funct3)
      3'b000:  taken = (op_a == fwd_b);
      3'b001:  taken = (op_a != fwd_b);
      3'b100:  taken = ($signed(op_a) < $signed(fwd_b));
      3'b101:  taken = !($signed(op_a) < $signed(fwd_b));
      3'b110:  taken = (op_a < fwd_b);
      3'b111:  taken = !(op_a < fwd_b);
      default: taken = 1'b0;
    endcase
  end

  // Redirect to IF is combinational and deliberately not gated by stall
  assign jalr_sum           = op_a + bus.id_ex_imm;
  assign bus.pc_src         = bus.id_ex_valid & (bus.id_ex_jump_d | (bus.id_ex_branch_d & taken));
  assign bus.pc_branch_dest = bus.id_ex_jalr_d ? {jalr_sum[XLEN-1:1], 1'b0}
                                               : bus.id_ex_pc + bus.id_ex_imm;

  // EX/MEM next state: flush beats stall, stall holds, otherwise load
  always_comb begin
    valid_d      = valid_q;
    regwrite_d   = regwrite_q;
    memwrite_d   = memwrite_q;
    result_src_d = result_src_q;
    rd_d         = rd_q;
    alu_result_d = alu_result_q;
    reg_b_d      = reg_b_q;
    pc_plus_4_d  = pc_plus_4_q;
    if (bus.flush) begin
      valid_d      = 1'b0;
      regwrite_d   = 1'b0;
      memwrite_d   = 1'b0;
      result_src_d = '0;
      rd_d         = '0;
      alu_result_d = '0;
      reg_b_d      = '0;
      pc_plus_4_d  = '0;
    end else if (!bus.stall) begin
      valid_d      = bus.id_ex_valid;
      regwrite_d   = bus.id_ex_valid & bus.id_ex_regwrite_d;
      memwrite_d   = bus.id_ex_valid & bus.id_ex_memwrite_d;
      result_src_d = bus.id_ex_result_src_d;
      rd_d         = bus.id_ex_rd;
      alu_result_d = alu_res;
      reg_b_d      = fwd_b;
      pc_plus_4_d  = bus.id_ex_pc_plus_4;
    end
  end

  // EX/MEM register with synchronous reset
  always_ff @(posedge clk) begin
    if (reset == RESET_ACTIVE) begin
      valid_q      <= 1'b0;
      regwrite_q   <= 1'b0;
      memwrite_q   <= 1'b0;
      result_src_q <= '0;
      rd_q         <= '0;
      alu_result_q <= '0;
      reg_b_q      <= '0;
      pc_plus_4_q  <= '0;
    end else begin
      valid_q      <= valid_d;
      regwrite_q   <= regwrite_d;
      memwrite_q   <= memwrite_d;
      result_src_q <= result_src_d;
      rd_q         <= rd_d;
      alu_result_q <= alu_result_d;
      reg_b_q      <= reg_b_d;
      pc_plus_4_q  <= pc_plus_4_d;
    end
  end

  assign bus.ex_mem_valid      = valid_q;
  assign bus.ex_mem_regwrite   = regwrite_q;
  assign bus.ex_mem_memwrite   = memwrite_q;
  assign bus.ex_mem_result_src = result_src_q;
  assign bus.ex_mem_rd         = rd_q;
  assign bus.ex_mem_alu_result = alu_result_q;
  assign bus.ex_mem_reg_b      = reg_b_q;
  assign bus.ex_mem_pc_plus_4  = pc_plus_4_q;
endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed scenarios plus a randomized run
// against a behavioural model of the execute stage.
module tb_ex_stage;
  logic clk = 1'b0;
  logic reset;

  ex_stage_if #(.XLEN(32)) bus ();

  ex_stage #(.XLEN(32)) u_dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Model of the EX/MEM register contents
  logic        m_valid, m_rw, m_mw;
  logic [1:0]  m_rs;
  logic [4:0]  m_rd;
  logic [31:0] m_alu, m_b, m_pc4;

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    int unsigned sh;
    logic [31:0] r;
    sh = b % 32;
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd6:    return (a < b) ? 32'd1 : 32'd0;
      4'd7:    return a << sh;
      4'd8:    return a >> sh;
      4'd9: begin
        r = a >> sh;
        if (a[31]) r = r | ~(32'hFFFF_FFFF >> sh);
        return r;
      end
      4'd10:   return b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic ref_taken(input logic [2:0] f3, input logic [31:0] a,
                                     input logic [31:0] b);
    case (f3)
      3'd0:    return a == b;
      3'd1:    return a != b;
      3'd4:    return $signed(a) < $signed(b);
      3'd5:    return $signed(a) >= $signed(b);
      3'd6:    return a < b;
      3'd7:    return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  // Expected combinational view of the current ID/EX inputs
  task automatic model_comb(output logic src, output logic [31:0] dest,
                            output logic [31:0] alu, output logic [31:0] fb);
    logic [31:0] oa, ob;
    oa = (bus.fwd_a_sel == 2'b01) ? m_alu : (bus.fwd_a_sel == 2'b10) ? bus.wb_data
                                                                     : bus.id_ex_reg_a;
    fb = (bus.fwd_b_sel == 2'b01) ? m_alu : (bus.fwd_b_sel == 2'b10) ? bus.wb_data
                                                                     : bus.id_ex_reg_b;
    ob   = bus.id_ex_alu_src_d ? bus.id_ex_imm : fb;
    alu  = ref_alu(bus.id_ex_alu_control_d, oa, ob);
    src  = bus.id_ex_valid &&
           (bus.id_ex_jump_d || (bus.id_ex_branch_d && ref_taken(bus.id_ex_branch_funct3, oa, fb)));
    dest = bus.id_ex_jalr_d ? ((oa + bus.id_ex_imm) & 32'hFFFF_FFFE)
                            : bus.id_ex_pc + bus.id_ex_imm;
  endtask

  // One clock: update the model at the edge, return at the following falling edge
  task automatic tick();
    logic s;
    logic [31:0] d, a, fb;
    model_comb(s, d, a, fb);
    @(posedge clk);
    if (!reset || bus.flush) begin
      {m_valid, m_rw, m_mw, m_rs, m_rd, m_alu, m_b, m_pc4} = '0;
    end else if (!bus.stall) begin
      m_valid = bus.id_ex_valid;
      m_rw    = bus.id_ex_valid && bus.id_ex_regwrite_d;
      m_mw    = bus.id_ex_valid && bus.id_ex_memwrite_d;
      m_rs    = bus.id_ex_result_src_d;
      m_rd    = bus.id_ex_rd;
      m_alu   = a;
      m_b     = fb;
      m_pc4   = bus.id_ex_pc_plus_4;
    end
    @(negedge clk);
  endtask

  task automatic idle();
    reset = 1'b1;
    bus.stall = 1'b0;               bus.flush = 1'b0;
    bus.id_ex_valid = 1'b0;         bus.id_ex_pc = '0;
    bus.id_ex_pc_plus_4 = '0;       bus.id_ex_reg_a = '0;
    bus.id_ex_reg_b = '0;           bus.id_ex_imm = '0;
    bus.id_ex_rd = '0;              bus.id_ex_regwrite_d = 1'b0;
    bus.id_ex_memwrite_d = 1'b0;    bus.id_ex_jump_d = 1'b0;
    bus.id_ex_branch_d = 1'b0;      bus.id_ex_alu_src_d = 1'b0;
    bus.id_ex_jalr_d = 1'b0;        bus.id_ex_branch_funct3 = '0;
    bus.id_ex_result_src_d = '0;    bus.id_ex_alu_control_d = '0;
    bus.fwd_a_sel = '0;             bus.fwd_b_sel = '0;
    bus.wb_data = '0;
  endtask

  task automatic randomize_inputs();
    bus.id_ex_valid = 1'($urandom_range(0, 3) != 0);
    bus.id_ex_pc = $urandom & 32'hFFFF_FFFC;
    bus.id_ex_pc_plus_4 = bus.id_ex_pc + 32'd4;
    bus.id_ex_reg_a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
    bus.id_ex_reg_b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
    bus.id_ex_imm = $urandom;
    bus.id_ex_rd = 5'($urandom);
    bus.id_ex_regwrite_d = 1'($urandom);
    bus.id_ex_memwrite_d = 1'($urandom);
    bus.id_ex_jump_d = ($urandom_range(0, 5) == 0);
    bus.id_ex_branch_d = 1'($urandom);
    bus.id_ex_alu_src_d = 1'($urandom);
    bus.id_ex_jalr_d = 1'($urandom);
    bus.id_ex_branch_funct3 = 3'($urandom);
    bus.id_ex_result_src_d = 2'($urandom);
    bus.id_ex_alu_control_d = 4'($urandom);
    bus.fwd_a_sel = 2'($urandom);
    bus.fwd_b_sel = 2'($urandom);
    bus.wb_data = $urandom;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      randomize_inputs();
      reset = 1'b0;
      if (i == 1) bus.id_ex_valid = 1'b0;
      #1;
      if (!bus.id_ex_valid) begin
        n_cmp++;
        if (bus.pc_src !== 1'b0) begin
          n_err++; $display("FAIL reset_pc_src got %b exp 0", bus.pc_src);
        end
      end
      tick();
      n_cmp++;
      if ({bus.ex_mem_valid, bus.ex_mem_regwrite, bus.ex_mem_memwrite, bus.ex_mem_result_src,
           bus.ex_mem_rd, bus.ex_mem_alu_result, bus.ex_mem_reg_b, bus.ex_mem_pc_plus_4} !== '0)
      begin
        n_err++;
        $display("FAIL reset_outputs cycle %0d got v%b rw%b mw%b rs%h rd%h alu%h b%h pc4%h exp 0",
                 i, bus.ex_mem_valid, bus.ex_mem_regwrite, bus.ex_mem_memwrite,
                 bus.ex_mem_result_src, bus.ex_mem_rd, bus.ex_mem_alu_result,
                 bus.ex_mem_reg_b, bus.ex_mem_pc_plus_4);
      end
    end
    idle();
  endtask

  task automatic test_alu();
    logic [3:0]  ops[5] = '{4'd0, 4'd1, 4'd5, 4'd6, 4'd9};
    logic [31:0] exp[5] = '{32'h0, 32'hFFFF_FFFE, 32'h1, 32'h0, 32'hF800_0000};
    for (int i = 0; i < 5; i++) begin
      idle();
      bus.id_ex_valid = 1'b1;
      bus.id_ex_alu_control_d = ops[i];
      bus.id_ex_reg_a = (i == 4) ? 32'h8000_0000 : 32'hFFFF_FFFF;
      bus.id_ex_reg_b = 32'h1;
      bus.id_ex_imm = 32'h4;
      bus.id_ex_alu_src_d = (i == 4);
      tick();
      n_cmp++;
      if (bus.ex_mem_alu_result !== exp[i]) begin
        n_err++;
        $display("FAIL alu_op%0d got %h exp %h", ops[i], bus.ex_mem_alu_result, exp[i]);
      end
    end
    idle();
  endtask

  task automatic test_branch();
    logic [2:0] f3[3] = '{3'b100, 3'b111, 3'b000};
    logic       exp[3] = '{1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      idle();
      bus.id_ex_valid = 1'b1;
      bus.id_ex_branch_d = 1'b1;
      bus.id_ex_branch_funct3 = f3[i];
      bus.id_ex_pc = 32'h100;
      bus.id_ex_imm = 32'h20;
      bus.id_ex_reg_a = 32'hFFFF_FFFF;
      bus.id_ex_reg_b = 32'h1;
      #1;
      n_cmp++;
      if (bus.pc_src !== exp[i]) begin
        n_err++; $display("FAIL branch_f3_%0d pc_src got %b exp %b", f3[i], bus.pc_src, exp[i]);
      end
      if (exp[i]) begin
        n_cmp++;
        if (bus.pc_branch_dest !== 32'h120) begin
          n_err++; $display("FAIL branch_dest got %h exp 00000120", bus.pc_branch_dest);
        end
      end
      tick();
    end
    idle();
  endtask

  task automatic test_jump();
    idle();
    bus.id_ex_valid = 1'b1;  bus.id_ex_jump_d = 1'b1;  bus.id_ex_jalr_d = 1'b1;
    bus.id_ex_reg_a = 32'h203;  bus.id_ex_imm = 32'h4;  bus.id_ex_pc = 32'h500;
    #1;
    n_cmp++;
    if (bus.pc_src !== 1'b1 || bus.pc_branch_dest !== 32'h206) begin
      n_err++;
      $display("FAIL jalr got src %b dest %h exp 1 00000206", bus.pc_src, bus.pc_branch_dest);
    end
    tick();
    idle();
    bus.id_ex_valid = 1'b1;  bus.id_ex_jump_d = 1'b1;  bus.id_ex_regwrite_d = 1'b1;
    bus.id_ex_result_src_d = 2'b10;  bus.id_ex_pc = 32'h100;  bus.id_ex_imm = 32'h8;
    bus.id_ex_pc_plus_4 = 32'h104;  bus.id_ex_rd = 5'd1;
    tick();
    n_cmp++;
    if (bus.ex_mem_pc_plus_4 !== 32'h104 || bus.ex_mem_regwrite !== 1'b1) begin
      n_err++;
      $display("FAIL jal got pc4 %h rw %b exp 00000104 1", bus.ex_mem_pc_plus_4,
               bus.ex_mem_regwrite);
    end
    bus.id_ex_valid = 1'b0;
    #1;
    n_cmp++;
    if (bus.pc_src !== 1'b0) begin
      n_err++; $display("FAIL invalid_jump_pc_src got %b exp 0", bus.pc_src);
    end
    tick();
    n_cmp++;
    if (bus.ex_mem_regwrite !== 1'b0 || bus.ex_mem_valid !== 1'b0) begin
      n_err++;
      $display("FAIL invalid_jump_regs got rw %b v %b exp 0 0", bus.ex_mem_regwrite,
               bus.ex_mem_valid);
    end
    idle();
  endtask

  task automatic test_forwarding();
    idle();
    bus.id_ex_valid = 1'b1;  bus.id_ex_alu_control_d = 4'd10;
    bus.id_ex_alu_src_d = 1'b1;  bus.id_ex_imm = 32'h10;
    tick();
    bus.fwd_a_sel = 2'b01;  bus.id_ex_reg_a = 32'h99;  bus.id_ex_imm = 32'h5;
    bus.id_ex_alu_control_d = 4'd0;
    tick();
    n_cmp++;
    if (bus.ex_mem_alu_result !== 32'h15) begin
      n_err++; $display("FAIL fwd_a got %h exp 00000015", bus.ex_mem_alu_result);
    end
    idle();
    bus.id_ex_valid = 1'b1;  bus.id_ex_memwrite_d = 1'b1;  bus.id_ex_alu_src_d = 1'b1;
    bus.fwd_b_sel = 2'b10;  bus.wb_data = 32'hAB;  bus.id_ex_reg_b = 32'h11;
    tick();
    n_cmp++;
    if (bus.ex_mem_reg_b !== 32'hAB || bus.ex_mem_memwrite !== 1'b1) begin
      n_err++;
      $display("FAIL fwd_b_store got b %h mw %b exp 000000ab 1", bus.ex_mem_reg_b,
               bus.ex_mem_memwrite);
    end
    idle();
  endtask

  task automatic test_stall_flush();
    idle();
    bus.id_ex_valid = 1'b1;  bus.id_ex_regwrite_d = 1'b1;  bus.id_ex_memwrite_d = 1'b1;
    bus.id_ex_alu_control_d = 4'd10;  bus.id_ex_alu_src_d = 1'b1;  bus.id_ex_imm = 32'h7;
    tick();
    for (int i = 0; i < 3; i++) begin
      randomize_inputs();
      bus.stall = 1'b1;  bus.flush = 1'b0;  reset = 1'b1;
      tick();
      n_cmp++;
      if (bus.ex_mem_alu_result !== 32'h7 || bus.ex_mem_valid !== 1'b1) begin
        n_err++;
        $display("FAIL stall_hold cycle %0d got %h v %b exp 00000007 1", i,
                 bus.ex_mem_alu_result, bus.ex_mem_valid);
      end
    end
    bus.flush = 1'b1;
    tick();
    n_cmp++;
    if ({bus.ex_mem_valid, bus.ex_mem_regwrite, bus.ex_mem_memwrite} !== 3'b000) begin
      n_err++;
      $display("FAIL flush_stall got v/rw/mw %b%b%b exp 000", bus.ex_mem_valid,
               bus.ex_mem_regwrite, bus.ex_mem_memwrite);
    end
    idle();
    bus.id_ex_valid = 1'b1;  bus.id_ex_regwrite_d = 1'b1;
    bus.id_ex_alu_control_d = 4'd10;  bus.id_ex_alu_src_d = 1'b1;  bus.id_ex_imm = 32'h33;
    bus.id_ex_pc_plus_4 = 32'h44;
    tick();
    bus.stall = 1'b1;  reset = 1'b0;
    tick();
    n_cmp++;
    if ({bus.ex_mem_valid, bus.ex_mem_regwrite, bus.ex_mem_alu_result,
         bus.ex_mem_pc_plus_4} !== '0) begin
      n_err++;
      $display("FAIL reset_in_stall got v %b rw %b alu %h pc4 %h exp 0", bus.ex_mem_valid,
               bus.ex_mem_regwrite, bus.ex_mem_alu_result, bus.ex_mem_pc_plus_4);
    end
    idle();
  endtask

  task automatic test_random();
    logic s;
    logic [31:0] d, a, fb;
    for (int i = 0; i < 400; i++) begin
      randomize_inputs();
      reset = ($urandom_range(0, 24) != 0);
      bus.flush = ($urandom_range(0, 9) == 0);
      bus.stall = ($urandom_range(0, 7) == 0);
      #1;
      model_comb(s, d, a, fb);
      n_cmp++;
      if (bus.pc_src !== s || (s && bus.pc_branch_dest !== d)) begin
        n_err++;
        $display("FAIL random_redirect cycle %0d got %b %h exp %b %h", i, bus.pc_src,
                 bus.pc_branch_dest, s, d);
      end
      tick();
      n_cmp++;
      if ({bus.ex_mem_valid, bus.ex_mem_regwrite, bus.ex_mem_memwrite, bus.ex_mem_result_src,
           bus.ex_mem_rd, bus.ex_mem_alu_result, bus.ex_mem_reg_b, bus.ex_mem_pc_plus_4} !==
          {m_valid, m_rw, m_mw, m_rs, m_rd, m_alu, m_b, m_pc4}) begin
        n_err++;
        $display("FAIL random_exmem cycle %0d got v%b rw%b mw%b rs%h rd%h alu%h b%h pc4%h exp v%b rw%b mw%b rs%h rd%h alu%h b%h pc4%h",
                 i, bus.ex_mem_valid, bus.ex_mem_regwrite, bus.ex_mem_memwrite,
                 bus.ex_mem_result_src, bus.ex_mem_rd, bus.ex_mem_alu_result, bus.ex_mem_reg_b,
                 bus.ex_mem_pc_plus_4, m_valid, m_rw, m_mw, m_rs, m_rd, m_alu, m_b, m_pc4);
      end
    end
    idle();
  endtask

  initial begin
    idle();
    reset = 1'b0;
    @(negedge clk);
    test_reset();
    test_alu();
    test_branch();
    test_jump();
    test_forwarding();
    test_stall_flush();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 5-stage RV32I pipeline. Sits directly downstream of the ID stage and consumes its ID/EX signals.
- Selects forwarded operands, performs the ALU operation and resolves branches and jumps, driving pc_src and pc_branch_dest back to IF.
- Holds the EX/MEM pipeline register, which feeds the MEM stage, with stall and flush control.

Parameters:
- XLEN, 32, datapath width.
- RESET_ACTIVE, 1'b0, reset assertion level; fixed, do not override.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset (reset==0 clears the stage on the next rising clk edge)
- stall  in  1  hold the EX/MEM register
- flush  in  1  load a bubble into EX/MEM
- id_ex_valid  in  1  EX holds a real instruction
- id_ex_pc  in  32  PC of the instruction
- id_ex_pc_plus_4  in  32  PC+4
- id_ex_reg_a / id_ex_reg_b  in  32  rs1/rs2 data from the register file
- id_ex_imm  in  32  sign-extended immediate
- id_ex_rd  in  5  destination register
- id_ex_regwrite_d, id_ex_memwrite_d, id_ex_jump_d, id_ex_branch_d, id_ex_alu_src_d  in  1 each  control
- id_ex_jalr_d  in  1  jump target taken from rs1+imm
- id_ex_branch_funct3  in  3  branch condition (funct3)
- id_ex_result_src_d  in  2  writeback select, passed through
- id_ex_alu_control_d  in  4  ALU operation
- fwd_a_sel / fwd_b_sel  in  2  00 register file, 01 ex_mem_alu_result, 10 wb_data, 11 register file
- wb_data  in  32  writeback-stage result
- pc_src  out  1  redirect IF (combinational)
- pc_branch_dest  out  32  redirect target (combinational)
- ex_mem_valid, ex_mem_regwrite, ex_mem_memwrite  out  1 each
- ex_mem_result_src  out  2
- ex_mem_rd  out  5
- ex_mem_alu_result, ex_mem_reg_b, ex_mem_pc_plus_4  out  32

Behaviour:
- Operand selection:
  - opA = fwd_a_sel mux.
  - fwdB = fwd_b_sel mux.
  - opB = id_ex_alu_src_d ? id_ex_imm : fwdB.
  - The forwarded ex_mem_alu_result is this block's own registered output.
- ALU, all 32-bit with wrap-around and no overflow flag:
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR.
  - 0101 SLT (signed), 0110 SLTU (unsigned): result is 1 or 0.
  - 0111 SLL, 1000 SRL, 1001 SRA: shift amount is opB[4:0].
  - 1010 PASS_B (LUI).
  - Any other code yields 0.
- Branch condition, comparing opA and fwdB per funct3:
  - 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU.
  - 010 and 011 are never taken.
- Redirect:
  - pc_src = id_ex_valid & (id_ex_jump_d | (id_ex_branch_d & taken)).
  - pc_branch_dest = id_ex_jalr_d ? ((opA+imm) & ~1) : (id_ex_pc+imm).
  - Both outputs are combinational and are valid in the same cycle the instruction sits in EX.
  - pc_branch_dest is don't-care when pc_src=0.
- Jumps (jump_d=1) write PC+4 downstream; result_src selects it. ex_mem_alu_result still carries the ALU value.
- EX/MEM register update, priority reset > flush > stall > load:
  - reset==0: all ex_mem_* outputs go to 0 on the next edge.
  - flush: ex_mem_valid, ex_mem_regwrite and ex_mem_memwrite go to 0. Data fields are don't-care but are cleared to 0.
  - stall: all ex_mem_* hold their value.
  - load: captures valid, control, rd, ALU result, fwdB (store data) and PC+4.
  - When id_ex_valid=0, the loaded regwrite and memwrite are forced to 0.
- Latency: one cycle from ID/EX inputs to ex_mem_* outputs. pc_src has zero latency.
- Stall does not gate pc_src. The hazard unit must not stall EX while pc_src=1.
- Flush and stall asserted together: flush wins.
- Reset asserted mid-stall: clears the register. Reset deasserted: normal loading resumes on the next edge.
- Asynchronous reset is forbidden. Only the reset level sampled at the rising clk edge has effect.

Test Plan:
- Reset: hold reset=0 for 2 cycles with random inputs -> every ex_mem_* output is 0; pc_src is 0 whenever id_ex_valid=0.
- ALU: reg_a=0xFFFFFFFF, reg_b=1, ADD -> ex_mem_alu_result=0 next cycle. SUB -> 0xFFFFFFFE. SLT -> 1. SLTU -> 0. SRA with opB=4 on 0x80000000 -> 0xF8000000.
- Branch: pc=0x100, imm=0x20, BLT with a=-1, b=1 -> pc_src=1, dest=0x120 in the same cycle. BGEU with the same operands -> pc_src=1. BEQ -> pc_src=0.
- JALR/JAL:
  - JALR with a=0x203, imm=4 -> dest=0x206, pc_src=1.
  - JAL with pc_plus_4=0x104 -> ex_mem_pc_plus_4=0x104, ex_mem_regwrite=1.
  - id_ex_valid=0 with jump_d=1 -> pc_src=0, ex_mem_regwrite=0.
- Forwarding: fwd_a_sel=01 after a previous result 0x10, reg_a=0x99, imm=5, ADD with alu_src=1 -> result 0x15. fwd_b_sel=10 with wb_data=0xAB, SW -> ex_mem_reg_b=0xAB.
- Stall/flush:
  - Load result 7, then stall 3 cycles with new inputs -> output stays 7.
  - flush+stall together -> ex_mem_valid=0, regwrite=0, memwrite=0.
  - reset=0 during stall -> outputs cleared.
